comparator_4bit: RTL and testbench
==================================

Name: comparator_4bit

Overview:
Registered magnitude comparator for two WIDTH-bit operands (default 4).
- Produces mutually exclusive equal / greater / less flags, with a valid qualifier.
- Optional two's-complement (signed) mode.
- Used as a leaf compare stage in datapath control logic. Outputs are registered for clean timing into downstream FSMs.

Parameters:
- WIDTH, 4, operand width in bits; legal range 1..32.
- SIGNED_EN, 1, when 1 the signed_mode input is honoured; when 0 the compare is always unsigned and signed_mode is ignored.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle; compare captured on this edge.
- signed_mode  input  1  1 = treat A, B as two's complement; 0 = unsigned.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  flags below are valid.
- A_eq_B  output  1  A equals B.
- A_gt_B  output  1  A greater than B.
- A_lt_B  output  1  A less than B.

Behaviour:
Reset:
- Asserting rst_n low immediately forces out_valid, A_eq_B, A_gt_B and A_lt_B to 0, regardless of clk.
- Deassertion is sampled on the next rising edge.

Compare and latency:
- On each rising edge with in_valid=1, the block compares A and B and registers the result.
- Latency is exactly 1 cycle: the flags and out_valid=1 appear after the edge that sampled in_valid=1.

Idle cycles:
- On an edge with in_valid=0, out_valid goes to 0.
- The flags hold their last values; they are only meaningful when out_valid=1.

Flag encoding:
- When out_valid=1, exactly one of A_eq_B, A_gt_B, A_lt_B is 1 (one-hot).
- Equality is a bitwise compare and does not depend on mode.

Arithmetic:
- Unsigned mode: operands are plain binary, 0..2^WIDTH-1.
- Signed mode (SIGNED_EN=1 and signed_mode=1): MSB is the sign bit.
  - When the MSBs differ, the operand with MSB=0 is greater.
  - Otherwise the remaining bits are compared unsigned.

Implementation:
- MSB-first cascade: per bit, compute eq_i = ~(A_i^B_i), gt_i = A_i&~B_i, lt_i = ~A_i&B_i.
- The first differing bit from the MSB decides the result.
- signed_mode swaps the gt/lt roles at the MSB only.

Boundary conditions:
- All-zero and all-ones operands: A_eq_B=1.
- Maximum spread (0 vs 2^WIDTH-1): unsigned gives lt; signed gives gt (0 > -1).
- WIDTH=1 works, with the MSB being the only bit.

Back-to-back and reset timing:
- Back-to-back in_valid=1 cycles give one result per cycle, with no bubbles.
- signed_mode is sampled together with the operands on the same edge.
- Reset asserted mid-stream drops any pending result. The first valid output after reset corresponds to the first in_valid=1 edge after rst_n is high.

Decomposition:
- Package comparator_pkg holds:
  - localparam CMP_WIDTH_MAX = 32;
  - a 3-bit result typedef cmp_res_t {eq, gt, lt};
  - constants CMP_EQ = 3'b100, CMP_GT = 3'b010, CMP_LT = 3'b001.
- One sub-module, comparator_cell: a combinational 1-bit cascade slice.
  - Inputs: a, b, and upstream eq/gt/lt.
  - Outputs: downstream eq/gt/lt, plus an invert_msb control for signed handling.
  - The top instantiates WIDTH cells in a generate loop and registers the final triple.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, A=5, B=3 -> out_valid=0 and all flags 0. Release rst_n -> first result appears one cycle after the first sampled in_valid.
- Unsigned sequence, one cycle apart, signed_mode=0: (0,0) -> eq; (5,3) -> gt; (6,6) -> eq; (3,10) -> lt; (15,15) -> eq. Each result appears 1 cycle later and is one-hot.
- Signed mode, signed_mode=1: (3,10) -> gt (3 > -6); (15,0) -> lt (-1 < 0); (8,7) -> lt (-8 < 7); (9,9) -> eq.
- Valid gating: in_valid pattern 1,0,1 with A=2, B=2 -> out_valid pattern 1,0,1 delayed by one cycle, with flags held during the gap.
- Async reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 -> outputs clear immediately, with no edge required.
- Exhaustive sweep: all 256 (A,B) pairs in both modes, compared against a reference model -> exactly one flag set each time, with correct relation.

Source files
------------

// File: rtl/comparator_pkg.sv
// -----------------------------------------------------------------------------
// comparator_pkg
// Shared types and constants for the registered magnitude comparator.
//   CMP_WIDTH_MAX : widest operand the comparator is meant to be built with
//   cmp_res_t     : packed {eq, gt, lt} result triple
//   CMP_EQ/GT/LT  : one-hot encodings of the three possible results
// -----------------------------------------------------------------------------
package comparator_pkg;

    localparam int CMP_WIDTH_MAX = 32;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_res_t;

    localparam logic [2:0] CMP_EQ = 3'b100;
    localparam logic [2:0] CMP_GT = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

endpackage : comparator_pkg

// File: rtl/comparator_4bit_if.sv
// -----------------------------------------------------------------------------
// comparator_4bit_if
// Operand/result bundle for comparator_4bit.
//   in_valid, signed_mode, A, B      : request side, driven by the master
//   out_valid, A_eq_B, A_gt_B, A_lt_B : registered result, driven by the slave
//
// Handshake: valid-only, no back-pressure. The slave samples A, B and
// signed_mode on every rising edge where in_valid=1 and presents the result
// with out_valid=1 exactly one cycle later. An edge with in_valid=0 drops
// out_valid; the flags keep their previous values and carry no meaning until
// out_valid returns high.
// -----------------------------------------------------------------------------
interface comparator_4bit_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             A_eq_B;
    logic             A_gt_B;
    logic             A_lt_B;

    modport master (
        output in_valid, signed_mode, A, B,
        input  out_valid, A_eq_B, A_gt_B, A_lt_B
    );

    modport slave (
        input  in_valid, signed_mode, A, B,
        output out_valid, A_eq_B, A_gt_B, A_lt_B
    );

endinterface : comparator_4bit_if

// File: rtl/comparator_cell.sv
// -----------------------------------------------------------------------------
// comparator_cell
// Combinational 1-bit slice of an MSB-first magnitude compare cascade.
//   i_a, i_b          : operand bits at this position
//   i_eq, i_gt, i_lt  : verdict from all more-significant bits
//   i_invert_msb      : swap the gt/lt meaning of this bit (sign bit in
//                       two's-complement mode)
//   o_eq, o_gt, o_lt  : verdict including this bit
// Once a more-significant bit has decided (i_eq=0) this slice passes the
// verdict through unchanged.
// -----------------------------------------------------------------------------
module comparator_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_eq,
    input  logic i_gt,
    input  logic i_lt,
    input  logic i_invert_msb,
    output logic o_eq,
    output logic o_gt,
    output logic o_lt
);

    logic w_bit_gt;
    logic w_bit_lt;
    logic w_sel_gt;
    logic w_sel_lt;

    assign w_bit_gt = i_a & ~i_b;
    assign w_bit_lt = ~i_a & i_b;

    // A set sign bit means negative, so at the MSB a 1 loses to a 0.
    assign w_sel_gt = i_invert_msb ? w_bit_lt : w_bit_gt;
    assign w_sel_lt = i_invert_msb ? w_bit_gt : w_bit_lt;

    assign o_eq = i_eq & ~(i_a ^ i_b);
    assign o_gt = i_gt | (i_eq & w_sel_gt);
    assign o_lt = i_lt | (i_eq & w_sel_lt);

endmodule : comparator_cell

// File: rtl/comparator_4bit.sv
// -----------------------------------------------------------------------------
// comparator_4bit
// Registered WIDTH-bit magnitude comparator with optional signed mode.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears out_valid and all flags
//   bus    : comparator_4bit_if slave port
//            in_valid/signed_mode/A/B in, out_valid/A_eq_B/A_gt_B/A_lt_B out
// Parameters:
//   WIDTH     : operand width, 1..CMP_WIDTH_MAX
//   SIGNED_EN : 1 honours bus.signed_mode, 0 forces unsigned compares
// One result per in_valid cycle, one cycle of latency, no bubbles.
// -----------------------------------------------------------------------------
module comparator_4bit
    import comparator_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    comparator_4bit_if.slave         bus
);

    // Cascade rails: index WIDTH is the seed entering the MSB cell,
    // index 0 is the final verdict leaving the LSB cell.
    logic     w_eq [WIDTH:0];
    logic     w_gt [WIDTH:0];
    logic     w_lt [WIDTH:0];
    logic     w_signed;
    cmp_res_t w_res;

    logic     r_valid;
    cmp_res_t r_res;

    assign w_signed = SIGNED_EN ? bus.signed_mode : 1'b0;

    // Nothing decided above the MSB: start out equal.
    assign w_eq[WIDTH] = 1'b1;
    assign w_gt[WIDTH] = 1'b0;
    assign w_lt[WIDTH] = 1'b0;

    genvar gi;
    generate
        for (gi = WIDTH - 1; gi >= 0; gi--) begin : g_cell
            comparator_cell u_cell (
                .i_a          (bus.A[gi]),
                .i_b          (bus.B[gi]),
                .i_eq         (w_eq[gi+1]),
                .i_gt         (w_gt[gi+1]),
                .i_lt         (w_lt[gi+1]),
                .i_invert_msb ((gi == WIDTH - 1) ? w_signed : 1'b0),
                .o_eq         (w_eq[gi]),
                .o_gt         (w_gt[gi]),
                .o_lt         (w_lt[gi])
            );
        end
    endgenerate

    assign w_res.eq = w_eq[0];
    assign w_res.gt = w_gt[0];
    assign w_res.lt = w_lt[0];

    // Flags only load on a valid sample, so they hold across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_res   <= '0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_res <= w_res;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.A_eq_B    = r_res.eq;
    assign bus.A_gt_B    = r_res.gt;
    assign bus.A_lt_B    = r_res.lt;

endmodule : comparator_4bit

// File: tb/tb_comparator_4bit.sv
// -----------------------------------------------------------------------------
// tb_comparator_4bit
// Self-checking bench for comparator_4bit (WIDTH=4, SIGNED_EN=1).
// Expected results come from an integer-arithmetic model of the compare
// rules and flow through exp_q; held flags are tracked for idle cycles.
// -----------------------------------------------------------------------------
module tb_comparator_4bit;
    import comparator_pkg::*;

    localparam int W = 4;

    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;

    // Expected {out_valid, eq, gt, lt} per clocked step.
    logic [3:0] exp_q[$];
    logic [2:0] held_flags;

    comparator_4bit_if #(.WIDTH(W)) bus ();

    comparator_4bit #(
        .WIDTH     (W),
        .SIGNED_EN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int to_value(input logic sm, input logic [W-1:0] x);
        int v;
        v = int'(x);
        if (sm && x[W-1]) v = v - (1 << W);
        return v;
    endfunction

    function automatic logic [2:0] model(input logic sm, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        int va;
        int vb;
        va = to_value(sm, a);
        vb = to_value(sm, b);
        if (va == vb) return CMP_EQ;
        else if (va > vb) return CMP_GT;
        else return CMP_LT;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] observed();
        return {bus.out_valid, bus.A_eq_B, bus.A_gt_B, bus.A_lt_B};
    endfunction

    // ---------------- driver ----------------
    // Drive one cycle, let the edge sample it, then check #1 after the edge.
    task automatic step(input string tag, input logic v, input logic sm,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        logic [3:0] exp_v;
        bus.in_valid    = v;
        bus.signed_mode = sm;
        bus.A           = a;
        bus.B           = b;
        if (v) held_flags = model(sm, a, b);
        exp_q.push_back({v, held_flags});
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        check(tag, observed(), exp_v);
        if (v) check({tag, "_onehot"}, {3'b000, $countones(observed() & 4'b0111) == 1},
                     4'b0001);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        held_flags   = 3'b000;

        // Reset held while a valid request is presented.
        rst_n           = 1'b0;
        bus.in_valid    = 1'b1;
        bus.signed_mode = 1'b0;
        bus.A           = 4'd5;
        bus.B           = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", observed(), 4'b0000);

        // Release between edges; the next edge samples (5,3).
        @(negedge clk);
        rst_n = 1'b1;
        step("first_after_reset", 1'b1, 1'b0, 4'd5, 4'd3);

        // Unsigned sequence, back to back.
        step("u_0_0",   1'b1, 1'b0, 4'd0,  4'd0);
        step("u_5_3",   1'b1, 1'b0, 4'd5,  4'd3);
        step("u_6_6",   1'b1, 1'b0, 4'd6,  4'd6);
        step("u_3_10",  1'b1, 1'b0, 4'd3,  4'd10);
        step("u_15_15", 1'b1, 1'b0, 4'd15, 4'd15);
        step("u_0_15",  1'b1, 1'b0, 4'd0,  4'd15);

        // Signed sequence.
        step("s_3_10",  1'b1, 1'b1, 4'd3,  4'd10);
        step("s_15_0",  1'b1, 1'b1, 4'd15, 4'd0);
        step("s_8_7",   1'b1, 1'b1, 4'd8,  4'd7);
        step("s_9_9",   1'b1, 1'b1, 4'd9,  4'd9);
        step("s_0_15",  1'b1, 1'b1, 4'd0,  4'd15);

        // Valid gating with held flags in the gap.
        step("gate_1",  1'b1, 1'b0, 4'd2, 4'd2);
        step("gate_0",  1'b0, 1'b0, 4'd7, 4'd1);
        step("gate_1b", 1'b1, 1'b0, 4'd2, 4'd2);

        // Asynchronous reset mid-stream, checked before any edge.
        step("pre_async", 1'b1, 1'b0, 4'd9, 4'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", observed(), 4'b0000);
        held_flags = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_async", 1'b1, 1'b1, 4'd9, 4'd4);

        // Exhaustive sweep in both modes.
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    step(m ? "sweep_s" : "sweep_u", 1'b1, m[0], a[W-1:0], b[W-1:0]);
                end
            end
        end

        // Random traffic with random valid gaps and mode changes.
        for (int n = 0; n < 200; n++) begin
            step("rand",
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_comparator_4bit
